// File: rtl/vec_mem_sequencer.sv
// Vector memory sequencer: gates on a start word, then turns each vector
// request into LANES single-element memory accesses, one lane per cycle.
module vec_mem_sequencer #(
  parameter int WIDTH      = 24,
  parameter int LANES      = 4,
  parameter int START_ADDR = 180302,
  parameter int OUT_LO     = 24,
  parameter int OUT_HI     = 10024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [WIDTH-1:0]         req_addr,
  input  logic [WIDTH*LANES-1:0]   req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH*LANES-1:0]   resp_rdata,
  output logic                     resp_err,
  output logic                     busy,
  output logic                     mem_we,
  output logic [WIDTH-1:0]         mem_a,
  output logic [WIDTH-1:0]         mem_wd,
  input  logic [WIDTH-1:0]         mem_rd
);

  // state      | meaning
  // WAIT_START | polling START_ADDR until bit 0 of the read word is set
  // IDLE       | ready for a vector request
  // ACCESS     | one memory access per lane, lane counter 0..LANES-1
  // DONE       | response presented, held until resp_ready
  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    IDLE       = 2'd1,
    ACCESS     = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [WIDTH-1:0] START_A = WIDTH'(START_ADDR);
  localparam logic [WIDTH-1:0] LO_A    = WIDTH'(OUT_LO);
  localparam logic [WIDTH-1:0] HI_A    = WIDTH'(OUT_HI);
  localparam logic [LW-1:0]    LAST    = LW'(LANES - 1);

  state_t                   state, state_nxt;
  logic [LW-1:0]            lane;
  logic                     we_q;
  logic [WIDTH-1:0]         base_q;
  logic [WIDTH*LANES-1:0]   wdata_q;
  logic [WIDTH*LANES-1:0]   rdata_q;
  logic                     err_q;

  logic [WIDTH-1:0]         lane_addr;
  logic                     in_range;
  logic                     lane_err;
  logic                     last_lane;
  logic                     accept;

  // Base plus lane wraps naturally at WIDTH bits.
  assign lane_addr = base_q + WIDTH'(lane);
  assign in_range  = (lane_addr >= LO_A) && (lane_addr < HI_A);
  assign lane_err  = we_q ? !in_range
                          : ((lane_addr >= HI_A) && (lane_addr != START_A));
  assign last_lane = (lane == LAST);
  assign accept    = (state == IDLE) && req_valid;

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_a      = '0;
    mem_wd     = '0;
    case (state)
      WAIT_START: begin
        mem_a = START_A;
        if (mem_rd[0]) state_nxt = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_a = lane_addr;
        if (we_q) begin
          mem_wd = wdata_q[int'(lane)*WIDTH +: WIDTH];
          mem_we = in_range;
        end
        if (last_lane) state_nxt = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = WAIT_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_START;
      lane    <= '0;
      we_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we;
        base_q  <= req_addr;
        wdata_q <= req_wdata;
        lane    <= '0;
        rdata_q <= '0;
        err_q   <= 1'b0;
      end else if (state == ACCESS) begin
        // Loads keep the captured word even when the lane is flagged.
        if (!we_q) rdata_q[int'(lane)*WIDTH +: WIDTH] <= mem_rd;
        if (lane_err) err_q <= 1'b1;
        if (!last_lane) lane <= lane + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer: directed cases from the
// requirements plus randomized requests against a lane-by-lane reference model.
module tb_vec_mem_sequencer;
  localparam int W     = 24;
  localparam int L     = 4;
  localparam int START = 180302;
  localparam int LO    = 24;
  localparam int HI    = 10024;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_we = 1'b0;
  logic [W-1:0]   req_addr = '0;
  logic [W*L-1:0] req_wdata = '0;
  logic           resp_valid;
  logic           resp_ready = 1'b0;
  logic [W*L-1:0] resp_rdata;
  logic           resp_err;
  logic           busy;
  logic           mem_we;
  logic [W-1:0]   mem_a;
  logic [W-1:0]   mem_wd;
  logic [W-1:0]   mem_rd;

  logic           start_bit = 1'b0;
  logic [W-1:0]   salt = '0;
  logic [2*W-1:0] obs_q[$];
  int             n_checks = 0;
  int             n_pass = 0;

  vec_mem_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Memory: start word at START, otherwise a salted function of the address.
  function automatic logic [W-1:0] mem_val(input logic [W-1:0] a);
    if (a == W'(START)) return {{(W-1){1'b0}}, start_bit};
    return W'({8'd0, a} * 32'd3) + salt;
  endfunction

  always_comb begin
    if (mem_a == W'(START)) mem_rd = {{(W-1){1'b0}}, start_bit};
    else                    mem_rd = W'({8'd0, mem_a} * 32'd3) + salt;
  end

  always @(posedge clk) if (mem_we) obs_q.push_back({mem_a, mem_wd});

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) begin n_pass++; end
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_req(input logic we, input logic [W-1:0] addr, input logic [W*L-1:0] wd,
                        input int hold, input bit pend, input logic [W-1:0] p_addr);
    logic [W*L-1:0] exp_rd;
    logic           exp_err;
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   la[L];
    logic           lwe[L];
    logic           inr;
    int             n;
    exp_rd  = '0;
    exp_err = 1'b0;
    for (int i = 0; i < L; i++) begin
      la[i] = addr + W'(i);
      inr   = (la[i] >= LO) && (la[i] < HI);
      lwe[i] = we && inr;
      if (we) begin
        if (inr) exp_q.push_back({la[i], wd[i*W +: W]});
        else     exp_err = 1'b1;
      end else begin
        exp_rd[i*W +: W] = mem_val(la[i]);
        if (la[i] >= HI && la[i] != W'(START)) exp_err = 1'b1;
      end
    end
    obs_q.delete();
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    tick();
    req_valid = 1'b0; req_we = ~we; req_addr = W'($urandom); req_wdata = {$urandom, $urandom, $urandom};
    for (int i = 0; i < L; i++) begin
      chk($sformatf("lane%0d_addr", i), mem_a, la[i]);
      chk($sformatf("lane%0d_we", i), mem_we, lwe[i]);
      chk($sformatf("lane%0d_no_resp", i), resp_valid, 0);
      tick();
    end
    chk("resp_valid", resp_valid, 1);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_err", resp_err, exp_err);
    chk("done_not_ready", req_ready, 0);
    chk("done_mem_we", mem_we, 0);
    if (pend) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = p_addr;
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_err", resp_err, exp_err);
      chk("hold_not_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("after_hs_valid", resp_valid, 0);
    chk("after_hs_ready", req_ready, 1);
    chk("write_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("write%0d", i), obs_q[i], exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]   a;
    logic [W*L-1:0] wd;
    tick(); tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_a", mem_a, W'(START));
    chk("rst_busy", busy, 1);
    rst_n = 1'b1;
    chk("first_cycle_mem_a", mem_a, W'(START));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gate_not_ready", req_ready, 0);
      chk("gate_mem_a", mem_a, W'(START));
    end
    start_bit = 1'b1;
    chk("gate_still_closed", req_ready, 0);
    tick();
    chk("gate_open_ready", req_ready, 1);
    chk("idle_mem_a", mem_a, 0);
    chk("idle_busy", busy, 0);

    do_req(1'b1, W'(100), {24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA}, 0, 1'b0, '0);
    do_req(1'b0, W'(20), '0, 0, 1'b0, '0);
    do_req(1'b1, W'(10022), {24'h444444, 24'h333333, 24'h222222, 24'h111111}, 0, 1'b0, '0);
    do_req(1'b0, W'(500), '0, 5, 1'b1, W'(3000));
    do_req(1'b0, W'(3000), '0, 0, 1'b0, '0);
    do_req(1'b1, 24'hFFFFFE, {$urandom, $urandom, $urandom}, 1, 1'b0, '0);
    do_req(1'b0, 24'hFFFFFE, '0, 0, 1'b0, '0);
    do_req(1'b0, W'(START - 2), '0, 0, 1'b0, '0);

    // Reset in the middle of a store, after lanes 0 and 1 are written.
    obs_q.delete();
    req_valid = 1'b1; req_we = 1'b1; req_addr = W'(200);
    req_wdata = {24'h000004, 24'h000003, 24'h000002, 24'h000001};
    chk("mid_pre_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    chk("mid_lane2_addr", mem_a, W'(202));
    start_bit = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_mem_a", mem_a, W'(START));
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_err", resp_err, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_wait_ready", req_ready, 0);
      chk("mid_wait_mem_we", mem_we, 0);
    end
    chk("mid_write_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("mid_write0", obs_q[0], {24'd200, 24'h000001});
      chk("mid_write1", obs_q[1], {24'd201, 24'h000002});
    end
    start_bit = 1'b1;
    tick();
    chk("mid_reopen_ready", req_ready, 1);

    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 4))
        0:       a = W'($urandom_range(0, 200));
        1:       a = W'($urandom_range(10018, 10026));
        2:       a = 24'hFFFFFC + W'($urandom_range(0, 3));
        3:       a = W'(START - 3 + $urandom_range(0, 6));
        default: a = W'($urandom);
      endcase
      wd   = {$urandom, $urandom, $urandom};
      salt = W'($urandom);
      do_req($urandom_range(0, 1) == 1, a, wd, $urandom_range(0, 3), 1'b0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vec_mem_sequencer.md
VEC_MEM_SEQUENCER -- requirements
Module: vec_mem_sequencer

Interface
REQ-001 The block SHALL have one clock, clk; reset SHALL be asynchronous and active-low, named rst_n.
REQ-002 Parameter WIDTH, default 24, SHALL set the word and address width.
REQ-003 Parameter LANES, default 4, SHALL set the elements per vector access.
REQ-004 Parameter START_ADDR, default 180302, SHALL set the start-switch address.
REQ-005 Parameter OUT_LO, default 24, SHALL set the first writable output address.
REQ-006 Parameter OUT_HI, default 10024, SHALL set the exclusive upper bound of the output region.
REQ-007 Ports SHALL be, as name / direction / width / meaning:
  clk  in  1  clock
  rst_n  in  1  async active-low reset
  req_valid  in  1  vector request offered
  req_ready  out  1  sequencer accepts the request
  req_we  in  1  1 = vector store, 0 = vector load
  req_addr  in  WIDTH  base element address
  req_wdata  in  WIDTH*LANES  store data; lane i at bits [i*WIDTH +: WIDTH]
  resp_valid  out  1  operation complete
  resp_ready  in  1  consumer takes the response
  resp_rdata  out  WIDTH*LANES  load data, same lane packing
  resp_err  out  1  at least one lane was out of range
  busy  out  1  high whenever state is not IDLE
  mem_we  out  1  memory write enable
  mem_a  out  WIDTH  memory address (a2)
  mem_wd  out  WIDTH  memory write data
  mem_rd  in  WIDTH  memory read data (rd2), combinational from mem_a

Function
REQ-008 The FSM SHALL have states WAIT_START, IDLE, ACCESS and DONE.
REQ-009 In WAIT_START: mem_a=START_ADDR, mem_we=0, req_ready=0; on a clk edge with mem_rd[0]=1 the FSM SHALL go to IDLE, otherwise stay.
REQ-010 In IDLE: req_ready=1, mem_a=0, mem_we=0; on req_valid&req_ready the block SHALL latch req_we, req_addr and req_wdata, clear lane counter, resp_rdata and resp_err, and go to ACCESS.
REQ-011 In ACCESS: one lane per cycle, lane counter k from 0 to LANES-1, with mem_a=(base+k) mod 2^WIDTH.
REQ-012 For a load, the block SHALL register mem_rd into lane k of resp_rdata at the end of that cycle.
REQ-013 For a store, mem_wd SHALL equal latched lane k and mem_we SHALL be 1 only if OUT_LO <= mem_a < OUT_HI; otherwise mem_we=0 and resp_err is set.
REQ-014 A load lane with mem_a >= OUT_HI and mem_a != START_ADDR SHALL set resp_err; the captured value is still stored.
REQ-015 After lane LANES-1 the FSM SHALL go to DONE.
REQ-016 Latency: with acceptance at edge T, lanes SHALL occupy cycles T+1..T+LANES and resp_valid SHALL be 1 from cycle T+LANES+1.
REQ-017 In DONE: resp_valid=1, req_ready=0, mem_we=0, mem_a=0; resp_rdata and resp_err SHALL be stable until resp_valid&resp_ready, then the FSM SHALL go to IDLE.
REQ-018 req_valid outside IDLE SHALL be ignored with no latching; the requester holds it.
REQ-019 Address wrap: base+k SHALL overflow modulo 2^WIDTH without error flagging beyond the REQ-013/014 range checks.
REQ-020 A store never writes a lane out of order and never writes twice; exactly one mem_we pulse per in-range lane.
REQ-021 The FSM SHALL never return to WAIT_START except through reset.

Reset
REQ-022 On rst_n=0 the block SHALL immediately force state=WAIT_START, mem_we=0, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0 and the lane counter to 0, including mid-ACCESS; a partially completed store SHALL NOT resume.
REQ-023 After rst_n rises the block SHALL drive mem_a=START_ADDR from the first cycle.

Verification
REQ-024 Start gate: mem_rd=0 for 10 cycles, then mem_rd=1 -> req_ready stays 0 while mem_rd=0, then rises the cycle after the sampling edge; mem_a=180302 throughout the wait.
REQ-025 Store: req_addr=100, wdata lanes {A,B,C,D} -> mem_we pulses at a2=100,101,102,103 with wd A..D, resp_valid at T+5, resp_err=0.
REQ-026 Load: req_addr=20, memory returns addr*3 -> resp_rdata lanes {60,63,66,69}; resp_err=0.
REQ-027 Range: store at req_addr=10022 -> writes at 10022 and 10023 only, no mem_we at 10024 or 10025, resp_err=1.
REQ-028 Backpressure: resp_ready=0 for 5 cycles in DONE with a new req_valid pending -> response held stable, req_ready=0, and the new request is accepted only after the handshake.
REQ-029 Reset mid-store after lane 1 -> mem_we=0 at once, state WAIT_START, lanes 2-3 never written.
